// File: rtl/assert_reporter_pkg.sv
// Shared types and helpers for the assertion reporter: FSM encoding and saturating add.
package assert_reporter_pkg;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ENC_RUN     = 2'd0;
    localparam logic [STATE_W-1:0] ENC_DRAIN   = 2'd1;
    localparam logic [STATE_W-1:0] ENC_STOPPED = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN     = ENC_RUN,
        ST_DRAIN   = ENC_DRAIN,
        ST_STOPPED = ENC_STOPPED
    } state_e;

    // One spare bit holds the carry, so an overflow clamps to max_val instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/assert_reporter_popcount.sv
// Combinational population count of a W-bit vector (module assert_popcount).
module assert_popcount
    import assert_reporter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]             vec_i,
    output logic [$clog2(W+1)-1:0]   count_o
);
    localparam int OW = $clog2(W + 1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + OW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/assert_reporter.sv
// Assertion error/warning accounting: holdoff gating, saturating counts, first-error capture, stop FSM.
// Optional: define ASSERT_STOP_ON_WARNING_EN to let accepted warnings start the stop sequence too.
module assert_reporter
    import assert_reporter_pkg::*;
#(
    parameter int N_ERR     = 8,
    parameter int N_WARN    = 8,
    parameter int CNT_W     = 16,
    parameter int HOLDOFF   = 4,
    parameter int DRAIN_CYC = 3
) (
    input  logic                                     clk,
    input  logic                                     reset_l,
    input  logic [N_ERR-1:0]                         err_vec,
    input  logic [N_WARN-1:0]                        warn_vec,
    input  logic                                     clear,
    output logic                                     message_on,
    output logic [CNT_W-1:0]                         error_count,
    output logic [CNT_W-1:0]                         warning_count,
    output logic                                     first_err_valid,
    output logic [((N_ERR > 1) ? $clog2(N_ERR) : 1)-1:0] first_err_idx,
    output logic                                     stop_req,
    output logic [STATE_W-1:0]                       state
);
    localparam int IDX_W  = (N_ERR > 1) ? $clog2(N_ERR) : 1;
    localparam int EPOP_W = $clog2(N_ERR + 1);
    localparam int WPOP_W = $clog2(N_WARN + 1);
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int DR_W   = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLDOFF);
    localparam logic [DR_W-1:0]   DRAIN_LOAD = DR_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    localparam logic [32:0]       CNT_MAX    = (33'd1 << CNT_W) - 33'd1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              message_on_q, message_on_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d, warn_cnt_q, warn_cnt_d;
    logic              first_valid_q, first_valid_d;
    logic [IDX_W-1:0]  first_idx_q, first_idx_d, low_idx;
    state_e            state_q, state_d;
    logic [DR_W-1:0]   drain_q, drain_d;

    logic [N_ERR-1:0]  err_acc;
    logic [N_WARN-1:0] warn_acc;
    logic [EPOP_W-1:0] err_pop;
    logic [WPOP_W-1:0] warn_pop;
    logic [31:0]       err_sum, warn_sum;
    logic              stop_trig;

    assign err_acc  = message_on_q ? err_vec  : '0;
    assign warn_acc = message_on_q ? warn_vec : '0;

    assert_popcount #(.W(N_ERR))  u_err_pop  (.vec_i(err_acc),  .count_o(err_pop));
    assert_popcount #(.W(N_WARN)) u_warn_pop (.vec_i(warn_acc), .count_o(warn_pop));

    // Clear replaces the old count as the base, so same-cycle events still land.
    assign err_sum  = sat_add(clear ? 32'd0 : 32'(err_cnt_q),  32'(err_pop),  CNT_MAX[31:0]);
    assign warn_sum = sat_add(clear ? 32'd0 : 32'(warn_cnt_q), 32'(warn_pop), CNT_MAX[31:0]);

`ifdef ASSERT_STOP_ON_WARNING_EN
    assign stop_trig = (|err_acc) | (|warn_acc);
`else
    assign stop_trig = |err_acc;
`endif

    always_comb begin
        low_idx = '0;
        for (int i = N_ERR - 1; i >= 0; i--) begin
            if (err_acc[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        hold_d        = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
        message_on_d  = message_on_q | (hold_q <= HOLD_W'(1));
        err_cnt_d     = err_sum[CNT_W-1:0];
        warn_cnt_d    = warn_sum[CNT_W-1:0];
        first_valid_d = first_valid_q & ~clear;
        first_idx_d   = clear ? '0 : first_idx_q;
        if ((|err_acc) && (clear || !first_valid_q)) begin
            first_valid_d = 1'b1;
            first_idx_d   = low_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            hold_q        <= HOLD_INIT;
            message_on_q  <= 1'b0;
            err_cnt_q     <= '0;
            warn_cnt_q    <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end else begin
            hold_q        <= hold_d;
            message_on_q  <= message_on_d;
            err_cnt_q     <= err_cnt_d;
            warn_cnt_q    <= warn_cnt_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
        end
    end

    // Stop FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Stop FSM: next state; DRAIN lasts DRAIN_CYC cycles, skipped entirely when zero
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (stop_trig) begin
                    state_d = (DRAIN_CYC == 0) ? ST_STOPPED : ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_STOPPED;
                else               drain_d = drain_q - DR_W'(1);
            end
            ST_STOPPED: state_d = ST_STOPPED;
            default:    state_d = ST_RUN;
        endcase
    end

    // Stop FSM: outputs
    always_comb begin
        stop_req = (state_q == ST_STOPPED);
        state    = state_q;
    end

    assign message_on      = message_on_q;
    assign error_count     = err_cnt_q;
    assign warning_count   = warn_cnt_q;
    assign first_err_valid = first_valid_q;
    assign first_err_idx   = first_idx_q;

endmodule

// File: tb/tb_assert_reporter.sv
// Directed self-checking bench for assert_reporter (CNT_W=4, HOLDOFF=4, DRAIN_CYC=3).
module tb_assert_reporter;
    logic       clk = 1'b0;
    logic       reset_l;
    logic [7:0] err_vec, warn_vec;
    logic       clear;
    logic       message_on, first_err_valid, stop_req;
    logic [3:0] error_count, warning_count;
    logic [2:0] first_err_idx;
    logic [1:0] state;

    int n_pass  = 0;
    int n_total = 0;
`ifdef ASSERT_STOP_ON_WARNING_EN
    localparam int WARN_STOPS = 1;
`else
    localparam int WARN_STOPS = 0;
`endif

    assert_reporter #(.N_ERR(8), .N_WARN(8), .CNT_W(4), .HOLDOFF(4), .DRAIN_CYC(3)) dut (
        .clk(clk), .reset_l(reset_l), .err_vec(err_vec), .warn_vec(warn_vec), .clear(clear),
        .message_on(message_on), .error_count(error_count), .warning_count(warning_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
        .stop_req(stop_req), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_holdoff();
        reset_l = 1'b0; err_vec = '0; warn_vec = '0; clear = 1'b0;
        tick();
        reset_l = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_l = 1'b0; err_vec = '0; warn_vec = '0; clear = 1'b0;
        repeat (2) tick();
        chk("rst_msg", 32'(message_on), 0);
        chk("rst_ecnt", 32'(error_count), 0);
        chk("rst_wcnt", 32'(warning_count), 0);
        chk("rst_valid", 32'(first_err_valid), 0);
        chk("rst_stop", 32'(stop_req), 0);
        chk("rst_state", 32'(state), 0);
        $display("reset: msg=%0d ecnt=%0d state=%0d", message_on, error_count, state);

        // Holdoff with err 0x01 every cycle, then the stop sequence from that error
        reset_l = 1'b1; err_vec = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_msg", 32'(message_on), (i == 3) ? 1 : 0);
            chk("hold_ecnt", 32'(error_count), 0);
        end
        tick();
        err_vec = '0;
        chk("hold_first_cnt", 32'(error_count), 1);
        chk("drain_state0", 32'(state), 1);
        chk("first_idx0", 32'(first_err_idx), 0);
        $display("holdoff: msg=%0d ecnt=%0d state=%0d", message_on, error_count, state);
        tick();
        chk("drain_state1", 32'(state), 1);
        chk("drain_stop1", 32'(stop_req), 0);
        tick();
        chk("drain_state2", 32'(state), 1);
        tick();
        chk("stopped_state", 32'(state), 2);
        chk("stopped_req", 32'(stop_req), 1);
        err_vec = 8'h06;
        tick();
        err_vec = '0;
        chk("stopped_cnt", 32'(error_count), 3);
        chk("stopped_idx", 32'(first_err_idx), 0);
        chk("stopped_hold", 32'(stop_req), 1);
        $display("stop: state=%0d stop_req=%0d ecnt=%0d", state, stop_req, error_count);
        reset_l = 1'b0; err_vec = 8'hFF;
        tick();
        err_vec = '0;
        chk("rst_stop_req", 32'(stop_req), 0);
        chk("rst_stop_msg", 32'(message_on), 0);
        chk("rst_stop_cnt", 32'(error_count), 0);
        chk("rst_stop_state", 32'(state), 0);
        chk("rst_stop_valid", 32'(first_err_valid), 0);

        // Popcount, first capture, saturation and clear
        reset_and_holdoff();
        chk("msg_on", 32'(message_on), 1);
        err_vec = 8'b0010_1100;
        tick();
        chk("pop_cnt", 32'(error_count), 3);
        chk("pop_idx", 32'(first_err_idx), 2);
        chk("pop_valid", 32'(first_err_valid), 1);
        err_vec = 8'h80;
        tick();
        chk("later_cnt", 32'(error_count), 4);
        chk("later_idx", 32'(first_err_idx), 2);
        $display("popcount: ecnt=%0d idx=%0d", error_count, first_err_idx);
        err_vec = 8'hFF;
        tick(); chk("sat_12", 32'(error_count), 12);
        tick(); chk("sat_15", 32'(error_count), 15);
        tick(); chk("sat_hold", 32'(error_count), 15);
        err_vec = 8'h03; clear = 1'b1;
        tick();
        chk("clear_cnt", 32'(error_count), 2);
        chk("clear_idx", 32'(first_err_idx), 0);
        chk("clear_valid", 32'(first_err_valid), 1);
        chk("clear_state", 32'(state), 2);
        err_vec = '0;
        tick();
        clear = 1'b0;
        chk("clear0_cnt", 32'(error_count), 0);
        chk("clear0_valid", 32'(first_err_valid), 0);
        $display("saturate/clear: ecnt=%0d valid=%0d", error_count, first_err_valid);

        // Warnings: ignored during holdoff, counted after, FSM effect depends on build
        reset_l = 1'b0;
        tick();
        reset_l = 1'b1; warn_vec = 8'hFF;
        repeat (4) tick();
        chk("warn_holdoff", 32'(warning_count), 0);
        warn_vec = 8'h11;
        tick();
        warn_vec = '0;
        chk("warn_cnt", 32'(warning_count), 2);
        chk("warn_state", 32'(state), WARN_STOPS);
        chk("warn_valid", 32'(first_err_valid), 0);
        tick();
        chk("warn_state2", 32'(state), WARN_STOPS);
        $display("warnings: wcnt=%0d state=%0d", warning_count, state);

        // Reset in the middle of DRAIN
        reset_and_holdoff();
        err_vec = 8'h10;
        tick();
        err_vec = '0;
        chk("md_state", 32'(state), 1);
        tick();
        reset_l = 1'b0;
        tick();
        chk("md_state_rst", 32'(state), 0);
        chk("md_cnt_rst", 32'(error_count), 0);
        chk("md_msg_rst", 32'(message_on), 0);
        reset_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("md_stop", 32'(stop_req), 0);
            chk("md_msg", 32'(message_on), (i == 3) ? 1 : 0);
        end
        $display("mid-drain reset: state=%0d stop_req=%0d msg=%0d", state, stop_req, message_on);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/assert_reporter.md
# assert_reporter

Synthesizable producer side of the assertion error/warning accounting. It collects per-cycle assertion-fire pulses from checkers and gates them during a post-reset holdoff. It keeps saturating error and warning counts and captures the first failing source. A stop FSM then requests simulation/emulation stop. The block sits beside the checkers and drives the counts and stop request consumed by the message/exit logic.

## Interface
- `N_ERR`, default 8: number of error sources.
- `N_WARN`, default 8: number of warning sources.
- `CNT_W`, default 16: counter width.
- `HOLDOFF`, default 4: cycles after reset release before messages are enabled (0 allowed).
- `DRAIN_CYC`, default 3: cycles between stop decision and `stop_req` (0 allowed).
- `clk` in 1: clock.
- `reset_l` in 1: reset. **One clock; reset is synchronous and active-low.**
- `err_vec` in N_ERR: one bit per error source, 1 = fired this cycle.
- `warn_vec` in N_WARN: one bit per warning source, 1 = fired this cycle.
- `clear` in 1: zero both counters and the first-error capture.
- `message_on` out 1: assertion checking enabled.
- `error_count` out CNT_W: accepted errors, saturating.
- `warning_count` out CNT_W: accepted warnings, saturating.
- `first_err_valid` out 1: `first_err_idx` is valid.
- `first_err_idx` out $clog2(N_ERR): lowest-index source of the first accepted error.
- `stop_req` out 1: level; stop requested.
- `state` out 2: FSM state (RUN=0, DRAIN=1, STOPPED=2).

## Operation
- Reset (`reset_l`=0 at edge) forces all outputs to 0, state to RUN and the holdoff counter to HOLDOFF.
- Holdoff: counter decrements each cycle with `reset_l`=1. `message_on` goes 1 when it reaches 0 and stays 1 until reset.
- Accept: while `message_on`=0, `err_vec`/`warn_vec` are ignored entirely. While 1, each counter adds the popcount of its vector (multiple bits = multiple events).
- Arithmetic: the sum is computed at CNT_W+1 bits and clamped to 2^CNT_W−1. A counter never wraps.
- First error: on the first cycle with any accepted error bit and `first_err_valid`=0, capture the lowest set index and set valid. Later errors do not change it.
- `clear`: counter next value = popcount of the same-cycle accepted events. Capture is re-armed and takes same-cycle errors. FSM state is unaffected.
- FSM:
  - RUN→DRAIN when any error is accepted this cycle.
  - DRAIN counts DRAIN_CYC cycles, then →STOPPED. With DRAIN_CYC=0, RUN→STOPPED directly.
  - STOPPED is held until reset; `stop_req`=1 only in STOPPED.
- Counting continues in DRAIN and STOPPED.

## Timing
- Inputs are sampled at the `clk` rising edge. Counters, capture and state update at that edge, so outputs are valid 1 cycle after the event.
- `message_on` asserts at the edge HOLDOFF cycles after the first edge with `reset_l`=1. With HOLDOFF=0 it asserts at that first edge.
- Error accepted at edge T: state=DRAIN after T, `stop_req`=1 after edge T+DRAIN_CYC.
- Reset mid-DRAIN or STOPPED: everything returns to reset values on that edge, holdoff restarts, and same-cycle inputs are dropped.
- Saturated counter plus `clear` in the same cycle: clear applies.

## Configuration
- `ASSERT_STOP_ON_WARNING_EN`:
  - Defined: an accepted warning triggers RUN→DRAIN exactly as an error does. `first_err_*` still tracks errors only.
  - Undefined: warnings are only counted and never affect the FSM.

## Structure
- Package `assert_reporter_pkg`:
  - state enum (RUN/DRAIN/STOPPED)
  - saturating-add function
  - state-encoding constants
- One sub-module, `assert_popcount` (parameter W; combinational count of set bits, output $clog2(W+1) bits), instantiated once per vector.
- FSM, holdoff counter and drain counter live in the top module.

## Test plan
- Holdoff: HOLDOFF=4, `err_vec`=8'h01 every cycle from reset release → `message_on` rises after edge 4; `error_count` first reads 1 the following cycle.
- Popcount plus first capture: `err_vec`=8'b0010_1100 for one cycle → `error_count`=3, `first_err_idx`=2, valid=1. A later 8'h80 leaves idx at 2.
- Saturation: CNT_W=4, feed 8'hFF for 3 cycles → `error_count`=15 and held. Then `clear` with `err_vec`=8'h03 → 2.
- Stop sequence: DRAIN_CYC=3, single error at edge T → `state` DRAIN after T, `stop_req`=1 after T+3, held. Reset in STOPPED → `stop_req`=0, `message_on`=0.
- Warnings: `warn_vec`=8'h11 once, macro undefined → `warning_count`=2, state stays RUN. Macro defined → DRAIN, `first_err_valid`=0.
- Reset mid-DRAIN: reset at DRAIN cycle 1 → all outputs 0, no `stop_req`, holdoff restarts.
